// File: rtl/shapool_ctrl_pkg.sv
// Shared definitions for the shapool job controller.
//   - ctrl_state_e : controller FSM states (IDLE=0, LOAD=1, RUN=2, DONE=3)
//   - *_W          : widths of the job parameter fields handed to the pool
package shapool_ctrl_pkg;

   localparam int unsigned SHA_STATE_W   = 256;
   localparam int unsigned MSG_HEAD_W    = 96;
   localparam int unsigned DIFF_W        = 8;
   localparam int unsigned NONCE_START_W = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StRun  = 2'd2,
      StDone = 2'd3
   } ctrl_state_e;

endpackage

// File: rtl/shapool_run_timer.sv
// Saturating run-cycle counter with terminal-count compare.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_clear        : zero the count (job acceptance)
//   i_enable       : count this cycle (RUN)
//   i_limit        : cycle budget, 0 = unlimited
//   o_count        : registered count, saturates at all-ones
//   o_terminal     : this enabled cycle is the last one of the budget
module shapool_run_timer
   import shapool_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 40
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic             i_enable,
   input  logic [WIDTH-1:0] i_limit,
   output logic [WIDTH-1:0] o_count,
   output logic             o_terminal
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != '1)) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   // Compare against limit-1 on the pre-increment count, so the budget expires
   // on exactly the limit-th enabled cycle.
   assign o_terminal = (i_limit != '0) && (r_count == (i_limit - WIDTH'(1)));
   assign o_count    = r_count;

endmodule

// File: rtl/shapool_job_ctrl.sv
// Job sequencer for the shapool hasher pool.
//   i_job_*     : job offer (valid/ready), parameters captured on acceptance
//   i_abort     : cancel current job while loading or running
//   o_pool_*    : registered job copy and pool reset
//   i_pool_*    : pool success strobe and nonce
//   o_result_*  : one result record per finished job (valid/ready)
//   o_busy      : loading or running
// Every output is registered; output flops are loaded from the next state.
module shapool_job_ctrl
   import shapool_ctrl_pkg::*;
#(
   parameter int unsigned POOL_SIZE_LOG2 = 0,
   parameter int unsigned NONCE_WIDTH    = 32 - POOL_SIZE_LOG2,
   parameter int unsigned RESET_CYCLES   = 2,
   parameter int unsigned TIMEOUT_WIDTH  = 40
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_job_valid,
   output logic                     o_job_ready,
   input  logic [SHA_STATE_W-1:0]   i_job_sha_state,
   input  logic [MSG_HEAD_W-1:0]    i_job_message_head,
   input  logic [DIFF_W-1:0]        i_job_difficulty,
   input  logic [NONCE_START_W-1:0] i_job_nonce_start,
   input  logic [TIMEOUT_WIDTH-1:0] i_job_timeout,
   input  logic                     i_abort,
   output logic                     o_pool_reset,
   output logic [SHA_STATE_W-1:0]   o_pool_sha_state,
   output logic [MSG_HEAD_W-1:0]    o_pool_message_head,
   output logic [DIFF_W-1:0]        o_pool_difficulty,
   output logic [NONCE_START_W-1:0] o_pool_nonce_start,
   input  logic                     i_pool_success,
   input  logic [NONCE_WIDTH-1:0]   i_pool_nonce,
   output logic                     o_result_valid,
   input  logic                     i_result_ready,
   output logic                     o_result_success,
   output logic [NONCE_WIDTH-1:0]   o_result_nonce,
   output logic [TIMEOUT_WIDTH-1:0] o_result_cycles,
   output logic                     o_busy
);

   localparam int unsigned LOAD_W = (RESET_CYCLES > 2) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(RESET_CYCLES - 1);

   ctrl_state_e                r_state, w_state_d;
   logic [LOAD_W-1:0]          r_load_cnt;
   logic [TIMEOUT_WIDTH-1:0]   r_timeout;
   logic                       r_job_ready, r_pool_reset, r_result_valid, r_busy;
   logic                       r_result_success;
   logic [NONCE_WIDTH-1:0]     r_result_nonce;
   logic [SHA_STATE_W-1:0]     r_sha_state;
   logic [MSG_HEAD_W-1:0]      r_message_head;
   logic [DIFF_W-1:0]          r_difficulty;
   logic [NONCE_START_W-1:0]   r_nonce_start;
   logic                       w_accept, w_run, w_hit_success, w_hit_timeout, w_terminal;

   shapool_run_timer #(
      .WIDTH (TIMEOUT_WIDTH)
   ) u_run_timer (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_clear    (w_accept),
      .i_enable   (w_run),
      .i_limit    (r_timeout),
      .o_count    (o_result_cycles),
      .o_terminal (w_terminal)
   );

   always_comb begin
      w_state_d     = r_state;
      w_accept      = 1'b0;
      w_run         = 1'b0;
      w_hit_success = 1'b0;
      w_hit_timeout = 1'b0;
      case (r_state)
         StIdle: begin
            if (i_job_valid && r_job_ready) begin
               w_accept  = 1'b1;
               w_state_d = StLoad;
            end
         end
         StLoad: begin
            if (i_abort) begin
               w_state_d = StIdle;
            end else if (r_load_cnt == LOAD_LAST) begin
               w_state_d = StRun;
            end
         end
         StRun: begin
            w_run = 1'b1;
            // Abort beats success, success beats timeout.
            if (i_abort) begin
               w_state_d = StIdle;
            end else if (i_pool_success) begin
               w_hit_success = 1'b1;
               w_state_d     = StDone;
            end else if (w_terminal) begin
               w_hit_timeout = 1'b1;
               w_state_d     = StDone;
            end
         end
         StDone: begin
            if (i_result_ready) begin
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state          <= StIdle;
         r_load_cnt       <= '0;
         r_timeout        <= '0;
         r_job_ready      <= 1'b0;
         r_pool_reset     <= 1'b1;
         r_result_valid   <= 1'b0;
         r_busy           <= 1'b0;
         r_result_success <= 1'b0;
         r_result_nonce   <= '0;
         r_sha_state      <= '0;
         r_message_head   <= '0;
         r_difficulty     <= '0;
         r_nonce_start    <= '0;
      end else begin
         r_state        <= w_state_d;
         r_job_ready    <= (w_state_d == StIdle);
         r_pool_reset   <= (w_state_d != StRun);
         r_result_valid <= (w_state_d == StDone);
         r_busy         <= (w_state_d == StLoad) || (w_state_d == StRun);

         if (w_accept) begin
            r_load_cnt     <= '0;
            r_timeout      <= i_job_timeout;
            r_sha_state    <= i_job_sha_state;
            r_message_head <= i_job_message_head;
            r_difficulty   <= i_job_difficulty;
            r_nonce_start  <= i_job_nonce_start;
         end else if (r_state == StLoad) begin
            r_load_cnt <= r_load_cnt + LOAD_W'(1);
         end

         if (w_hit_success) begin
            r_result_success <= 1'b1;
            r_result_nonce   <= i_pool_nonce;
         end else if (w_hit_timeout) begin
            r_result_success <= 1'b0;
            r_result_nonce   <= '0;
         end
      end
   end

   assign o_job_ready         = r_job_ready;
   assign o_pool_reset        = r_pool_reset;
   assign o_result_valid      = r_result_valid;
   assign o_busy              = r_busy;
   assign o_result_success    = r_result_success;
   assign o_result_nonce      = r_result_nonce;
   assign o_pool_sha_state    = r_sha_state;
   assign o_pool_message_head = r_message_head;
   assign o_pool_difficulty   = r_difficulty;
   assign o_pool_nonce_start  = r_nonce_start;

endmodule

// File: tb/tb_shapool_job_ctrl.sv
// Bench for shapool_job_ctrl: a stub pool and job driver push expected result
// records into a scoreboard queue; a monitor pops them on each result handshake.
module tb_shapool_job_ctrl;

   localparam int unsigned RC = 2;
   localparam int unsigned TW = 40;
   localparam int unsigned NW = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            job_valid;
   logic            job_ready;
   logic [255:0]    job_sha_state;
   logic [95:0]     job_message_head;
   logic [7:0]      job_difficulty;
   logic [7:0]      job_nonce_start;
   logic [TW-1:0]   job_timeout;
   logic            abort;
   logic            pool_reset;
   logic [255:0]    pool_sha_state;
   logic [95:0]     pool_message_head;
   logic [7:0]      pool_difficulty;
   logic [7:0]      pool_nonce_start;
   logic            pool_success;
   logic [NW-1:0]   pool_nonce;
   logic            result_valid;
   logic            result_ready;
   logic            result_success;
   logic [NW-1:0]   result_nonce;
   logic [TW-1:0]   result_cycles;
   logic            busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit            succ;
      logic [NW-1:0] nonce;
      logic [TW-1:0] cycles;
   } res_t;

   res_t sb_q[$];

   always #5 clk = ~clk;

   shapool_job_ctrl #(
      .POOL_SIZE_LOG2 (0),
      .NONCE_WIDTH    (NW),
      .RESET_CYCLES   (RC),
      .TIMEOUT_WIDTH  (TW)
   ) dut (
      .i_clk               (clk),
      .i_reset             (reset),
      .i_job_valid         (job_valid),
      .o_job_ready         (job_ready),
      .i_job_sha_state     (job_sha_state),
      .i_job_message_head  (job_message_head),
      .i_job_difficulty    (job_difficulty),
      .i_job_nonce_start   (job_nonce_start),
      .i_job_timeout       (job_timeout),
      .i_abort             (abort),
      .o_pool_reset        (pool_reset),
      .o_pool_sha_state    (pool_sha_state),
      .o_pool_message_head (pool_message_head),
      .o_pool_difficulty   (pool_difficulty),
      .o_pool_nonce_start  (pool_nonce_start),
      .i_pool_success      (pool_success),
      .i_pool_nonce        (pool_nonce),
      .o_result_valid      (result_valid),
      .i_result_ready      (result_ready),
      .o_result_success    (result_success),
      .o_result_nonce      (result_nonce),
      .o_result_cycles     (result_cycles),
      .o_busy              (busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Job outcome from the rules: the job ends at the first of success cycle k
   // or budget n (success wins a tie); an abort at or before that end cancels it.
   task automatic model(input int n, input int k, input int a,
                        output bit has_res, output bit succ, output int len);
      int stop;
      stop = k;
      if (n != 0 && (stop == 0 || n < stop)) stop = n;
      if (a != 0 && a <= stop) begin
         has_res = 0; succ = 0; len = a;
      end else begin
         has_res = 1; succ = (k != 0 && k == stop); len = stop;
      end
   endtask

   // Monitor: compare each accepted result record against the scoreboard.
   always @(negedge clk) begin
      if (!reset && result_valid) begin
         check("result_expected", 64'(sb_q.size() != 0), 64'd1);
         if (result_ready && sb_q.size() != 0) begin
            res_t e;
            e = sb_q.pop_front();
            check("result_success", 64'(result_success), 64'(e.succ));
            check("result_nonce", 64'(result_nonce), 64'(e.nonce));
            check("result_cycles", 64'(result_cycles), 64'(e.cycles));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_fields();
      for (int i = 0; i < 8; i++) job_sha_state = {job_sha_state[223:0], $urandom()};
      for (int i = 0; i < 3; i++) job_message_head = {job_message_head[63:0], $urandom()};
      job_difficulty  = 8'($urandom());
      job_nonce_start = 8'($urandom());
   endtask

   task automatic run_job(input int n, input int k, input int a, input logic [NW-1:0] nonce,
                          input int delay, input bit hold_valid, input int rst_at);
      bit            has_res, succ, rst_done;
      int            len, w, lc, rc;
      logic [255:0]  sha;
      logic [7:0]    ns;
      res_t          e, snap;
      model(n, k, a, has_res, succ, len);
      if (has_res && rst_at == 0) begin
         e.succ   = succ;
         e.nonce  = succ ? nonce : '0;
         e.cycles = TW'(len);
         sb_q.push_back(e);
      end
      rand_fields();
      sha         = job_sha_state;
      ns          = job_nonce_start;
      job_timeout = TW'(n);
      job_valid   = 1'b1;
      w = 0;
      while (!job_ready && w < 100) begin
         tick();
         w++;
      end
      check("accept_wait", 64'(w < 100), 64'd1);
      tick();
      job_valid = 1'b0;
      check("pool_sha_state", 64'(pool_sha_state == sha), 64'd1);
      check("pool_nonce_start", 64'(pool_nonce_start), 64'(ns));
      check("busy_load", 64'(busy), 64'd1);
      lc = 0;
      while (pool_reset && lc < 50) begin
         lc++;
         tick();
      end
      check("load_cycles", 64'(lc), 64'(RC));
      rc = 0;
      rst_done = 0;
      while (!pool_reset && rc < 200) begin
         rc++;
         if (rc == rst_at) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check("rst_pool_reset", 64'(pool_reset), 64'd1);
            check("rst_result_valid", 64'(result_valid), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_job_ready_low", 64'(job_ready), 64'd0);
            check("rst_pool_sha_zero", 64'(pool_sha_state == '0), 64'd1);
            tick();
            check("rst_job_ready", 64'(job_ready), 64'd1);
            rst_done = 1;
            break;
         end
         pool_success = (rc == k);
         abort        = (rc == a);
         pool_nonce   = (rc == k) ? nonce : NW'($urandom());
         tick();
      end
      pool_success = 1'b0;
      abort        = 1'b0;
      if (rst_done) return;
      check("run_cycles", 64'(rc), 64'(len));
      if (!has_res) begin
         check("abort_no_valid", 64'(result_valid), 64'd0);
         check("abort_job_ready", 64'(job_ready), 64'd1);
         check("abort_busy", 64'(busy), 64'd0);
         return;
      end
      check("result_valid_rise", 64'(result_valid), 64'd1);
      check("done_busy", 64'(busy), 64'd0);
      snap.succ   = result_success;
      snap.nonce  = result_nonce;
      snap.cycles = result_cycles;
      for (int i = 0; i < delay; i++) begin
         if (hold_valid) begin
            rand_fields();
            job_valid = 1'b1;
         end
         tick();
         check("bp_valid", 64'(result_valid), 64'd1);
         check("bp_stable", 64'({result_success, result_nonce, result_cycles} ==
                                {snap.succ, snap.nonce, snap.cycles}), 64'd1);
         check("bp_job_ready", 64'(job_ready), 64'd0);
         check("bp_pool_reset", 64'(pool_reset), 64'd1);
         check("bp_pool_hold", 64'(pool_sha_state == sha), 64'd1);
      end
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      check("post_hs_valid", 64'(result_valid), 64'd0);
      check("post_hs_job_ready", 64'(job_ready), 64'd1);
      check("post_hs_pool_hold", 64'(pool_sha_state == sha), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; job_valid = 1'b0; abort = 1'b0; pool_success = 1'b0;
      pool_nonce = '0; result_ready = 1'b0; job_timeout = '0;
      job_sha_state = '0; job_message_head = '0; job_difficulty = '0; job_nonce_start = '0;
      repeat (3) tick();
      check("reset_job_ready", 64'(job_ready), 64'd0);
      check("reset_pool_reset", 64'(pool_reset), 64'd1);
      check("reset_result_valid", 64'(result_valid), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_result_cycles", 64'(result_cycles), 64'd0);
      check("reset_pool_regs", 64'(pool_sha_state == '0 && pool_nonce_start == '0), 64'd1);
      reset = 1'b0;
      tick();
      check("reset_release_ready", 64'(job_ready), 64'd1);

      run_job(0, 10, 0, 32'h00AB_CDEF, 0, 0, 0);   // success
      run_job(5, 0, 0, 32'h1234_5678, 1, 0, 0);    // timeout
      run_job(0, 3, 3, 32'h5555_AAAA, 0, 0, 0);    // abort beats success
      run_job(0, 7, 0, 32'hCAFE_F00D, 20, 1, 0);   // backpressure, valid held
      run_job(4, 4, 0, 32'hBEEF_0001, 0, 0, 0);    // success/timeout tie
      run_job(0, 0, 0, 32'h0, 0, 0, 3);            // reset mid-RUN
      run_job(3, 0, 0, 32'h0, 0, 0, 0);            // recovery after reset

      for (int j = 0; j < 30; j++) begin
         int n, k, a;
         n = $urandom_range(0, 12);
         k = $urandom_range(0, 12);
         if (n == 0 && k == 0) k = 1;
         a = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
         run_job(n, k, a, $urandom(), $urandom_range(0, 3), 1'($urandom()), 0);
      end

      repeat (3) tick();
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shapool_job_ctrl.md
# shapool_job_ctrl

Sequencer between the host-side job interface and the `shapool` hasher pool. It accepts one job at a time over a valid/ready handshake and holds the pool in reset while the new job parameters settle. It then releases the pool and watches for success, timeout or abort. Each job ends with a single result record delivered over a second valid/ready handshake.

## Interface
- `POOL_SIZE_LOG2`, 0: log2 of hasher units; sets nonce width.
- `NONCE_WIDTH`, 32 - `POOL_SIZE_LOG2`: width of the pool nonce result.
- `RESET_CYCLES`, 2: cycles `pool_reset` is held in LOAD, minimum 2. This covers `difficulty_map` latency.
- `TIMEOUT_WIDTH`, 40: width of the run-cycle counter and of `job_timeout`.

Ports:
- `clk` input 1: single clock. Drives the pool, the difficulty map and this block.
- `reset` input 1: synchronous, active-high.
- `job_valid` input 1: job offered.
- `job_ready` output 1: block can accept a job. High only in IDLE.
- `job_sha_state` input 256: initial SHA-256 state.
- `job_message_head` input 96: first 96 bits of the message block.
- `job_difficulty` input 8: difficulty code passed to `difficulty_map`.
- `job_nonce_start` input 8: device nonce starting count.
- `job_timeout` input `TIMEOUT_WIDTH`: RUN-cycle budget. 0 means unlimited.
- `abort` input 1: cancel the current job.
- `pool_reset` output 1: reset to the pool and the difficulty map.
- `pool_sha_state`, `pool_message_head`, `pool_difficulty`, `pool_nonce_start` outputs 256/96/8/8: registered job copy.
- `pool_success` input 1: pool success strobe.
- `pool_nonce` input `NONCE_WIDTH`: pool nonce. Valid when `pool_success` is high.
- `result_valid` output 1: result record available.
- `result_ready` input 1: consumer accepts the result.
- `result_success` output 1: 1 = nonce found, 0 = timeout.
- `result_nonce` output `NONCE_WIDTH`: winning nonce. Zero on timeout.
- `result_cycles` output `TIMEOUT_WIDTH`: RUN cycles consumed.
- `busy` output 1: state is LOAD or RUN.

## Operation
- The state machine has four states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - `pool_reset`=1 and `job_ready`=1.
  - When `job_valid` and `job_ready` are both high, all job fields are captured into the `pool_*` registers. The run counter clears and the state moves to LOAD.
- LOAD:
  - `pool_reset`=1 for exactly `RESET_CYCLES` cycles, then the state moves to RUN.
- RUN:
  - `pool_reset`=0.
  - The run counter increments each cycle and saturates at all-ones.
  - On `pool_success`: `pool_nonce` is captured, `result_success`=1, and the state moves to DONE.
  - Otherwise, if `job_timeout`≠0 and the counter equals `job_timeout` - 1: `result_success`=0, `result_nonce`=0, and the state moves to DONE.
- DONE:
  - `pool_reset`=1, which freezes the pool so no further success is seen.
  - `result_valid`=1, with result fields stable until `result_ready` is high. The state then moves to IDLE.
- Abort:
  - `abort` in LOAD or RUN moves the state to IDLE next cycle. No result is produced.
  - Abort has priority over a same-cycle `pool_success` or timeout.
  - `abort` is ignored in IDLE and DONE.
- Simultaneous success and timeout in the same cycle: success wins.
- `pool_*` parameter registers change only on job acceptance. They hold their value through DONE and IDLE.
- Reset mid-operation: the next state is IDLE and any pending result is dropped.

## Timing
- Outputs during and after `reset`:
  - State is IDLE.
  - `pool_reset`=1, `result_valid`=0, `busy`=0.
  - `job_ready`=0 while `reset` is high, and 1 on the first cycle after it drops.
  - Result and `pool_*` registers are 0.
- Job accepted at edge T:
  - `pool_reset` stays 1 for cycles T+1 … T+`RESET_CYCLES`.
  - The first cycle with `pool_reset`=0 is T+`RESET_CYCLES`+1.
- `pool_success` sampled at edge S:
  - `result_valid`=1 from S+1.
  - `result_cycles` = number of RUN cycles including S.
- Timeout with `job_timeout`=N: `result_valid` rises after exactly N RUN cycles, with `result_cycles`=N.
- Result handshake at edge R: `job_ready`=1 from R+1. Back-to-back jobs therefore have a 1-cycle IDLE gap.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- `shapool_ctrl_pkg` holds:
  - the state enum (IDLE=0, LOAD=1, RUN=2, DONE=3);
  - constants `SHA_STATE_W`=256, `MSG_HEAD_W`=96, `DIFF_W`=8, `NONCE_START_W`=8.
- Sub-module `shapool_run_timer` contains the saturating `TIMEOUT_WIDTH` counter with clear, enable and terminal-count compare. The LOAD-length count reuses a small local counter.

## Test plan
- Success path:
  - Stimulus: job with `job_timeout`=0 and `RESET_CYCLES`=2. The stub pool asserts `pool_success` with `pool_nonce`=0x00ABCDEF on its 10th RUN cycle.
  - Required response: `pool_reset` is low for exactly 10 cycles, then `result_valid`=1 with success=1, nonce=0x00ABCDEF, cycles=10.
- Timeout:
  - Stimulus: `job_timeout`=5 and the pool never succeeds.
  - Required response: `result_valid` rises after 5 RUN cycles with success=0, nonce=0, cycles=5.
- Abort during RUN:
  - Stimulus: `abort` on RUN cycle 3, with `pool_success` asserted in the same cycle.
  - Required response: back in IDLE next cycle, `result_valid` never rises, `job_ready`=1.
- Result backpressure:
  - Stimulus: `result_ready` held low for 20 cycles, and `job_valid` held high the whole time.
  - Required response: result fields stay stable, `job_ready`=0, `pool_reset`=1 throughout. The next job is accepted 1 cycle after the handshake.
- Success/timeout tie:
  - Stimulus: `job_timeout`=4 and `pool_success` on RUN cycle 4.
  - Required response: success=1 with the captured nonce.
- Reset mid-RUN:
  - Stimulus: `reset` pulsed for 1 cycle during RUN.
  - Required response: next cycle `pool_reset`=1, `result_valid`=0, `busy`=0, and `job_ready`=1 one cycle after reset drops.
